// File: rtl/apb_pkg.sv
// Shared types and constants for the APB parameterised slave.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package apb_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_e;

    localparam int V_PEN_NOSETUP = 0;
    localparam int V_UNSTABLE    = 1;
    localparam int V_RANGE       = 2;
    localparam int NUM_VIOL      = 3;

    // Saturating add used by the violation counter.
    function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [1:0] n);
        logic [8:0] s;
        s = {1'b0, a} + {7'b0, n};
        return s[8] ? 8'hFF : s[7:0];
    endfunction

endpackage

// File: rtl/apb_regfile.sv
// DEPTH x DATA_W storage with one write port and one combinational read port.
// Latency: write lands on the next PCLK edge; read is same-cycle.
// Backpressure: none; out-of-range reads return zero, out-of-range writes are ignored.
module apb_regfile #(
    parameter int AW     = 6,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 16
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_we,
    input  logic [AW-1:0]     i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [AW-1:0]     i_raddr,
    output logic [DATA_W-1:0] o_rdata
);

    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic              w_wr_ok;
    logic              w_rd_ok;

    assign w_wr_ok = int'(i_waddr) < DEPTH;
    assign w_rd_ok = int'(i_raddr) < DEPTH;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_we && w_wr_ok) begin
            r_mem[i_waddr[IW-1:0]] <= i_wdata;
        end
    end

    assign o_rdata = w_rd_ok ? r_mem[i_raddr[IW-1:0]] : '0;

endmodule

// File: rtl/apb_param_slave.sv
// APB slave over a word register file with wait states and a protocol-violation checker.
// Latency: ACCESS completes after WAIT_CYCLES PREADY-low cycles; misuse in IDLE answers same-cycle.
// Backpressure: PREADY low while the wait counter runs; violations are flagged, never stall.
module apb_param_slave
    import apb_pkg::*;
#(
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 32,
    parameter int DEPTH       = 16,
    parameter int WAIT_CYCLES = 0
) (
    input  logic              PCLK,
    input  logic              PRESETn,
    input  logic              PSEL,
    input  logic              PENABLE,
    input  logic              PWRITE,
    input  logic [ADDR_W-1:0] PADDR,
    input  logic [DATA_W-1:0] PWDATA,
    output logic [DATA_W-1:0] PRDATA,
    output logic              PREADY,
    output logic              PSLVERR,
    input  logic              viol_clr,
    output logic [2:0]        viol_flags,
    output logic [7:0]        viol_count
);

    localparam int IDX_W = ADDR_W - 2;
    localparam int WC_W  = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

    state_e              r_state;
    state_e              w_state_nxt;
    logic [WC_W-1:0]     r_wait_cnt;
    logic [WC_W-1:0]     w_wait_nxt;
    logic [ADDR_W-1:0]   r_addr;
    logic                r_write;
    logic [DATA_W-1:0]   r_wdata;
    logic                r_v1;
    logic                w_v1_nxt;
    logic [2:0]          r_flags;
    logic [7:0]          r_count;

    logic                w_capture;
    logic                w_mismatch;
    logic                w_in_range;
    logic                w_we;
    logic                w_pready;
    logic                w_pslverr;
    logic [DATA_W-1:0]   w_prdata;
    logic [DATA_W-1:0]   w_rd;
    logic [NUM_VIOL-1:0] w_ev;
    logic [1:0]          w_ev_num;

    assign w_in_range = int'(r_addr[ADDR_W-1:2]) < DEPTH;
    assign w_mismatch = (PADDR != r_addr) || (PWRITE != r_write) || (PWDATA != r_wdata);

    always_comb begin
        w_state_nxt = r_state;
        w_wait_nxt  = r_wait_cnt;
        w_v1_nxt    = r_v1;
        w_capture   = 1'b0;
        w_we        = 1'b0;
        w_pready    = 1'b1;
        w_pslverr   = 1'b0;
        w_prdata    = '0;
        w_ev        = '0;
        case (r_state)
            IDLE: begin
                if (PSEL && PENABLE) begin
                    w_pslverr            = 1'b1;
                    w_ev[V_PEN_NOSETUP]  = 1'b1;
                end else if (PSEL) begin
                    w_capture   = 1'b1;
                    w_wait_nxt  = WC_W'(WAIT_CYCLES);
                    w_v1_nxt    = 1'b0;
                    w_state_nxt = ACCESS;
                end
            end
            ACCESS: begin
                w_pready = (r_wait_cnt == '0);
                if (!PSEL || !PENABLE) begin
                    // Dropped select/enable abandons the access outright.
                    w_ev[V_UNSTABLE] = !r_v1;
                    w_wait_nxt       = '0;
                    w_state_nxt      = IDLE;
                end else begin
                    if (w_mismatch) begin
                        w_ev[V_UNSTABLE] = !r_v1;
                        w_v1_nxt         = 1'b1;
                    end
                    if (r_wait_cnt != '0) begin
                        w_wait_nxt = r_wait_cnt - WC_W'(1);
                    end else begin
                        w_ev[V_RANGE] = !w_in_range;
                        w_pslverr     = r_v1 || w_mismatch || !w_in_range;
                        w_we          = r_write && !w_pslverr;
                        w_prdata      = (!r_write && w_in_range) ? w_rd : '0;
                        w_state_nxt   = IDLE;
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign w_ev_num = {1'b0, w_ev[0]} + {1'b0, w_ev[1]} + {1'b0, w_ev[2]};

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_state    <= IDLE;
            r_wait_cnt <= '0;
            r_addr     <= '0;
            r_write    <= 1'b0;
            r_wdata    <= '0;
            r_v1       <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_wait_cnt <= w_wait_nxt;
            r_v1       <= w_v1_nxt;
            if (w_capture) begin
                r_addr  <= PADDR;
                r_write <= PWRITE;
                r_wdata <= PWDATA;
            end
        end
    end

    // Clear wins over any violation raised in the same cycle.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_flags <= '0;
            r_count <= '0;
        end else if (viol_clr) begin
            r_flags <= '0;
            r_count <= '0;
        end else begin
            r_flags <= r_flags | w_ev;
            r_count <= sat_add8(r_count, w_ev_num);
        end
    end

    apb_regfile #(
        .AW     (IDX_W),
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_regfile (
        .i_clk   (PCLK),
        .i_rst_n (PRESETn),
        .i_we    (w_we),
        .i_waddr (r_addr[ADDR_W-1:2]),
        .i_wdata (r_wdata),
        .i_raddr (r_addr[ADDR_W-1:2]),
        .o_rdata (w_rd)
    );

    assign PREADY     = !PRESETn || w_pready;
    assign PSLVERR    = PRESETn && w_pslverr;
    assign PRDATA     = PRESETn ? w_prdata : '0;
    assign viol_flags = r_flags;
    assign viol_count = r_count;

endmodule

// File: tb/tb_apb_param_slave.sv
// Directed bench for apb_param_slave: three instances with WAIT_CYCLES 0, 1 and 2.
// Expected transfer results are queued at issue and compared when the access completes.
module tb_apb_param_slave;

    typedef struct {
        string       tag;
        logic [31:0] rdata;
        logic        err;
        logic [31:0] waits;
    } exp_t;

    logic        clk;
    logic        rst_n    [3];
    logic        psel     [3];
    logic        penable  [3];
    logic        pwrite   [3];
    logic [7:0]  paddr    [3];
    logic [31:0] pwdata   [3];
    logic [31:0] prdata   [3];
    logic        pready   [3];
    logic        pslverr  [3];
    logic        viol_clr [3];
    logic [2:0]  flags    [3];
    logic [7:0]  count    [3];

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        apb_param_slave #(
            .ADDR_W      (8),
            .DATA_W      (32),
            .DEPTH       (16),
            .WAIT_CYCLES (g)
        ) u_dut (
            .PCLK       (clk),
            .PRESETn    (rst_n[g]),
            .PSEL       (psel[g]),
            .PENABLE    (penable[g]),
            .PWRITE     (pwrite[g]),
            .PADDR      (paddr[g]),
            .PWDATA     (pwdata[g]),
            .PRDATA     (prdata[g]),
            .PREADY     (pready[g]),
            .PSLVERR    (pslverr[g]),
            .viol_clr   (viol_clr[g]),
            .viol_flags (flags[g]),
            .viol_count (count[g])
        );
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int d);
        @(negedge clk);
        psel[d]    = 1'b0;
        penable[d] = 1'b0;
        #1;
    endtask

    // Full SETUP+ACCESS transfer; leaves PSEL/PENABLE high so a following call is back-to-back.
    task automatic xfer(input int d, input logic wr, input logic [7:0] addr, input logic [31:0] wd,
                        input string tag, input logic [31:0] exp_rd, input logic exp_err);
        exp_t e;
        int   waits;
        logic [31:0] got_rd;
        logic        got_err;
        sb.push_back('{tag: tag, rdata: exp_rd, err: exp_err, waits: 32'(d)});
        @(negedge clk);
        psel[d] = 1'b1; penable[d] = 1'b0; pwrite[d] = wr; paddr[d] = addr; pwdata[d] = wd;
        @(negedge clk);
        penable[d] = 1'b1;
        #1;
        waits = 0;
        while (pready[d] !== 1'b1 && waits < 20) begin
            @(negedge clk);
            #1;
            waits++;
        end
        got_rd  = prdata[d];
        got_err = pslverr[d];
        e = sb.pop_front();
        chk({e.tag, ".waits"}, 32'(waits), e.waits);
        chk({e.tag, ".pslverr"}, {31'b0, got_err}, {31'b0, e.err});
        chk({e.tag, ".prdata"}, got_rd, e.rdata);
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            rst_n[i] = 1'b0; psel[i] = 1'b0; penable[i] = 1'b0; pwrite[i] = 1'b0;
            paddr[i] = '0; pwdata[i] = '0; viol_clr[i] = 1'b0;
        end
        // Reset outputs, even with a bogus PSEL&PENABLE presented.
        psel[0] = 1'b1; penable[0] = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        chk("rst.pready",  {31'b0, pready[0]},  32'd1);
        chk("rst.pslverr", {31'b0, pslverr[0]}, 32'd0);
        chk("rst.prdata",  prdata[0],           32'd0);
        chk("rst.flags",   {29'b0, flags[0]},   32'd0);
        chk("rst.count",   {24'b0, count[0]},   32'd0);
        @(negedge clk);
        psel[0] = 1'b0; penable[0] = 1'b0;
        for (int i = 0; i < 3; i++) rst_n[i] = 1'b1;

        // Zero-wait write then back-to-back read.
        xfer(0, 1'b1, 8'h08, 32'hDEADBEEF, "w0_wr08", 32'h0, 1'b0);
        xfer(0, 1'b0, 8'h08, 32'h0,        "w0_rd08", 32'hDEADBEEF, 1'b0);
        idle(0);
        chk("w0_idle.prdata", prdata[0], 32'd0);

        // PENABLE without SETUP.
        xfer(0, 1'b1, 8'h00, 32'h11111111, "w0_wr00", 32'h0, 1'b0);
        xfer(0, 1'b1, 8'h04, 32'h22222222, "w0_wr04", 32'h0, 1'b0);
        idle(0);
        @(negedge clk);
        psel[0] = 1'b1; penable[0] = 1'b1; pwrite[0] = 1'b1; paddr[0] = 8'h00; pwdata[0] = 32'h55;
        #1;
        chk("v0.pready",  {31'b0, pready[0]},  32'd1);
        chk("v0.pslverr", {31'b0, pslverr[0]}, 32'd1);
        idle(0);
        chk("v0.flags", {29'b0, flags[0]}, 32'b001);
        chk("v0.count", {24'b0, count[0]}, 32'd1);
        xfer(0, 1'b0, 8'h00, 32'h0, "v0_rd00", 32'h11111111, 1'b0);
        idle(0);

        // Two wait states.
        xfer(2, 1'b0, 8'h04, 32'h0,        "w2_rd04a", 32'h0, 1'b0);
        xfer(2, 1'b1, 8'h04, 32'hA5A5A5A5, "w2_wr04",  32'h0, 1'b0);
        xfer(2, 1'b0, 8'h04, 32'h0,        "w2_rd04b", 32'hA5A5A5A5, 1'b0);
        idle(2);

        // PADDR changes during the wait cycle; V1 must be counted only once.
        @(negedge clk);
        psel[1] = 1'b1; penable[1] = 1'b0; pwrite[1] = 1'b1; paddr[1] = 8'h04; pwdata[1] = 32'h1234;
        @(negedge clk);
        penable[1] = 1'b1; paddr[1] = 8'h0C;
        #1;
        chk("v1.wait_pready", {31'b0, pready[1]}, 32'd0);
        @(negedge clk);
        #1;
        chk("v1.done_pready",  {31'b0, pready[1]},  32'd1);
        chk("v1.done_pslverr", {31'b0, pslverr[1]}, 32'd1);
        idle(1);
        chk("v1.flags", {29'b0, flags[1]}, 32'b010);
        chk("v1.count", {24'b0, count[1]}, 32'd1);
        xfer(1, 1'b0, 8'h04, 32'h0, "v1_rd04", 32'h0, 1'b0);
        xfer(1, 1'b0, 8'h0C, 32'h0, "v1_rd0C", 32'h0, 1'b0);
        idle(1);

        // Out-of-range, counter saturation, clear priority.
        xfer(2, 1'b1, 8'h40, 32'hFFFF, "v2_wr40", 32'h0, 1'b1);
        idle(2);
        chk("v2.flags", {29'b0, flags[2]}, 32'b100);
        chk("v2.count", {24'b0, count[2]}, 32'd1);
        @(negedge clk);
        psel[2] = 1'b1; penable[2] = 1'b1;
        repeat (300) @(negedge clk);
        #1;
        chk("sat.count", {24'b0, count[2]}, 32'd255);
        chk("sat.flags", {29'b0, flags[2]}, 32'b101);
        viol_clr[2] = 1'b1;
        @(negedge clk);
        viol_clr[2] = 1'b0; psel[2] = 1'b0; penable[2] = 1'b0;
        #1;
        chk("clr.flags", {29'b0, flags[2]}, 32'd0);
        chk("clr.count", {24'b0, count[2]}, 32'd0);

        // Reset during a wait-state write.
        @(negedge clk);
        psel[1] = 1'b1; penable[1] = 1'b0; pwrite[1] = 1'b1; paddr[1] = 8'h08; pwdata[1] = 32'hCAFEF00D;
        @(negedge clk);
        penable[1] = 1'b1;
        #1;
        chk("rstacc.wait_pready", {31'b0, pready[1]}, 32'd0);
        rst_n[1] = 1'b0;
        #1;
        chk("rstacc.pready",  {31'b0, pready[1]},  32'd1);
        chk("rstacc.pslverr", {31'b0, pslverr[1]}, 32'd0);
        @(negedge clk);
        psel[1] = 1'b0; penable[1] = 1'b0; rst_n[1] = 1'b1;
        xfer(1, 1'b0, 8'h08, 32'h0, "rstacc_rd08", 32'h0, 1'b0);
        idle(1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
